// File: rtl/ulpi_reg_engine_if.sv
// Register-access engine bundle: PHY pad side plus REG_* request/ack side.
// Latency: none (wiring only).
// Backpressure: reqs are level-held until ack; the PHY throttles via nxt and claims the bus via dir.
interface ulpi_reg_engine_if;
    // ULPI pad side
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_d_in;
    logic [7:0] ulpi_d_out;
    logic       ulpi_d_oe;
    logic       ulpi_stp;
    // register request side
    logic [5:0] reg_addr;
    logic [7:0] reg_data_write;
    logic       reg_write_req;
    logic       reg_write_ack;
    logic       reg_read_req;
    logic       reg_read_ack;
    logic [7:0] reg_data_read;
    logic       reg_err;
    logic       busy;

    // Environment side: request initiator plus PHY
    modport master (
        output ulpi_dir, ulpi_nxt, ulpi_d_in,
        output reg_addr, reg_data_write, reg_write_req, reg_read_req,
        input  ulpi_d_out, ulpi_d_oe, ulpi_stp,
        input  reg_write_ack, reg_read_ack, reg_data_read, reg_err, busy
    );

    // Engine side
    modport slave (
        input  ulpi_dir, ulpi_nxt, ulpi_d_in,
        input  reg_addr, reg_data_write, reg_write_req, reg_read_req,
        output ulpi_d_out, ulpi_d_oe, ulpi_stp,
        output reg_write_ack, reg_read_ack, reg_data_read, reg_err, busy
    );
endinterface

// File: rtl/ulpi_reg_engine.sv
// ULPI link-side register engine: turns held write/read reqs into TXCMD register bus cycles.
// Latency: write ack 2 cycles after the TXCMD nxt edge; read ack 2 cycles after the TXCMD nxt edge.
// Backpressure: waits on nxt (with timeout), yields the bus on dir (with bounded retries).
module ulpi_reg_engine #(
    parameter int TIMEOUT = 64,
    parameter int RETRIES = 3
) (
    input  logic              clk,
    input  logic              rst,
    ulpi_reg_engine_if.slave  bus
);

    localparam int NW = $clog2(TIMEOUT);
    localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
    localparam logic [NW-1:0] NXT_LAST  = NW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

    typedef enum logic [3:0] {
        IDLE, WR_CMD, WR_DATA, WR_STP, RD_CMD, RD_TURN, RD_DATA, ABORT, DONE
    } state_t;

    state_t        state;
    logic          is_write;     // access type of the req being served
    logic          abort_low;    // dir seen low in ABORT; next cycle is the idle gap
    logic          drive_r;
    logic [7:0]    d_out;
    logic          stp;
    logic          write_ack;
    logic          read_ack;
    logic          err;
    logic [7:0]    data_read;
    logic [NW-1:0] nxt_cnt;
    logic [RW-1:0] retry_cnt;

    // TXCMD byte for a register write (10) or read (11)
    function automatic logic [7:0] txcmd(input logic wr, input logic [5:0] addr);
        return {1'b1, ~wr, addr};
    endfunction

    // Main access FSM; every pad and handshake output is a flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            abort_low <= 1'b0;
            drive_r   <= 1'b0;
            d_out     <= 8'h00;
            stp       <= 1'b0;
            write_ack <= 1'b0;
            read_ack  <= 1'b0;
            err       <= 1'b0;
            data_read <= 8'h00;
            nxt_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            write_ack <= 1'b0;
            read_ack  <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.ulpi_dir && (bus.reg_write_req || bus.reg_read_req)) begin
                        is_write  <= bus.reg_write_req;
                        retry_cnt <= '0;
                        nxt_cnt   <= '0;
                        drive_r   <= 1'b1;
                        d_out     <= txcmd(bus.reg_write_req, bus.reg_addr);
                        state     <= bus.reg_write_req ? WR_CMD : RD_CMD;
                    end
                end
                WR_CMD, RD_CMD: begin
                    if (bus.ulpi_dir) begin
                        // PHY took the bus: back off and retry later
                        drive_r   <= 1'b0;
                        d_out     <= 8'h00;
                        abort_low <= 1'b0;
                        state     <= ABORT;
                    end else if (bus.ulpi_nxt) begin
                        if (state == WR_CMD) begin
                            d_out <= bus.reg_data_write;
                            state <= WR_DATA;
                        end else begin
                            drive_r <= 1'b0;
                            d_out   <= 8'h00;
                            state   <= RD_TURN;
                        end
                    end else if (nxt_cnt == NXT_LAST) begin
                        // PHY never accepted the TXCMD: fail the access
                        drive_r <= 1'b0;
                        d_out   <= 8'h00;
                        err     <= 1'b1;
                        if (is_write) write_ack <= 1'b1;
                        else          read_ack  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        nxt_cnt <= nxt_cnt + 1'b1;
                    end
                end
                WR_DATA: begin
                    if (bus.ulpi_dir) begin
                        drive_r   <= 1'b0;
                        d_out     <= 8'h00;
                        abort_low <= 1'b0;
                        state     <= ABORT;
                    end else if (bus.ulpi_nxt) begin
                        stp   <= 1'b1;
                        d_out <= 8'h00;
                        state <= WR_STP;
                    end
                end
                WR_STP: begin
                    stp       <= 1'b0;
                    drive_r   <= 1'b0;
                    write_ack <= 1'b1;
                    state     <= DONE;
                end
                RD_TURN: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    if (bus.ulpi_dir && !bus.ulpi_nxt) begin
                        data_read <= bus.ulpi_d_in;
                        read_ack  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        // PHY receive preempted the read, or it never turned around
                        abort_low <= 1'b0;
                        state     <= ABORT;
                    end
                end
                ABORT: begin
                    if (!abort_low) begin
                        if (!bus.ulpi_dir) abort_low <= 1'b1;
                    end else begin
                        abort_low <= 1'b0;
                        if (retry_cnt == RETRY_MAX) begin
                            err <= 1'b1;
                            if (is_write) write_ack <= 1'b1;
                            else          read_ack  <= 1'b1;
                            state <= DONE;
                        end else begin
                            retry_cnt <= retry_cnt + 1'b1;
                            nxt_cnt   <= '0;
                            drive_r   <= 1'b1;
                            d_out     <= txcmd(is_write, bus.reg_addr);
                            state     <= is_write ? WR_CMD : RD_CMD;
                        end
                    end
                end
                DONE: begin
                    // one ack per req assertion: wait for the served req to drop
                    if (is_write ? !bus.reg_write_req : !bus.reg_read_req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output drive is released combinationally the moment the PHY raises dir
    assign bus.ulpi_d_oe     = drive_r & ~bus.ulpi_dir;
    assign bus.ulpi_d_out    = d_out;
    assign bus.ulpi_stp      = stp;
    assign bus.reg_write_ack = write_ack;
    assign bus.reg_read_ack  = read_ack;
    assign bus.reg_err       = err;
    assign bus.reg_data_read = data_read;
    assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_ulpi_reg_engine.sv
// Directed bench for ulpi_reg_engine with a scoreboard of expected acks.
// Latency: checks cycle-exact TXCMD/data/STP/ack sequencing and the NXT timeout.
// Backpressure: a scripted PHY drives nxt/dir/d_in, including aborts and resets.
module tb_ulpi_reg_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ulpi_reg_engine_if bus();

    ulpi_reg_engine #(.TIMEOUT(64), .RETRIES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       wr;
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   acks  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) for the link to drive a given TXCMD byte
    task automatic wait_tx(input string tag, input logic [7:0] cmd);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ulpi_d_oe && bus.ulpi_d_out == cmd) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.reg_write_ack || bus.reg_read_ack) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // PHY accepts TXCMD and data with nxt, then expects STP and the ack
    task automatic phy_write(input string tag, input logic [7:0] cmd, input logic [7:0] data);
        wait_tx({tag, "_txcmd"}, cmd);
        bus.ulpi_nxt = 1'b1;
        tick();
        chk({tag, "_data"}, 32'(bus.ulpi_d_out), 32'(data));
        tick();
        chk({tag, "_stp"}, 32'(bus.ulpi_stp), 32'd1);
        chk({tag, "_stp_d"}, 32'(bus.ulpi_d_out), 32'd0);
        bus.ulpi_nxt = 1'b0;
        tick();
        chk({tag, "_ack"}, 32'(bus.reg_write_ack), 32'd1);
        chk({tag, "_stp_off"}, 32'(bus.ulpi_stp), 32'd0);
    endtask

    // PHY accepts read TXCMD, turns around, returns din
    task automatic phy_read(input string tag, input logic [7:0] cmd, input logic [7:0] din);
        wait_tx({tag, "_txcmd"}, cmd);
        bus.ulpi_nxt = 1'b1;
        tick();
        chk({tag, "_turn_oe"}, 32'(bus.ulpi_d_oe), 32'd0);
        bus.ulpi_nxt  = 1'b0;
        bus.ulpi_dir  = 1'b1;
        bus.ulpi_d_in = din;
        tick();
        tick();
        chk({tag, "_ack"}, 32'(bus.reg_read_ack), 32'd1);
        chk({tag, "_data"}, 32'(bus.reg_data_read), 32'(din));
        bus.ulpi_dir = 1'b0;
    endtask

    // Scoreboard: every ack pops one expected completion
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.reg_write_ack || bus.reg_read_ack)) begin
            acks++;
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_write_ack", 32'(bus.reg_write_ack), 32'(e.wr));
                chk("sb_read_ack", 32'(bus.reg_read_ack), 32'(!e.wr));
                chk("sb_err", 32'(bus.reg_err), 32'(e.err));
                if (!e.wr) chk("sb_read_data", 32'(bus.reg_data_read), 32'(e.data));
            end
        end
    end

    initial begin
        int a0;
        int cyc;
        bus.ulpi_dir       = 1'b0;
        bus.ulpi_nxt       = 1'b0;
        bus.ulpi_d_in      = 8'h00;
        bus.reg_addr       = 6'h00;
        bus.reg_data_write = 8'h00;
        bus.reg_write_req  = 1'b0;
        bus.reg_read_req   = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_d_out", 32'(bus.ulpi_d_out), 32'd0);
        chk("rst_oe", 32'(bus.ulpi_d_oe), 32'd0);
        chk("rst_stp", 32'(bus.ulpi_stp), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_acks", 32'({bus.reg_write_ack, bus.reg_read_ack, bus.reg_err}), 32'd0);
        chk("rst_data_read", 32'(bus.reg_data_read), 32'd0);
        rst = 1'b0;
        tick();

        // Write 0x0A <= 0x55
        bus.reg_addr = 6'h0A;
        bus.reg_data_write = 8'h55;
        bus.reg_write_req = 1'b1;
        sb.push_back('{wr: 1'b1, err: 1'b0, data: 8'h00});
        tick();
        chk("wr_busy", 32'(bus.busy), 32'd1);
        phy_write("wr", 8'h8A, 8'h55);
        chk("wr_oe_off", 32'(bus.ulpi_d_oe), 32'd0);
        bus.reg_write_req = 1'b0;
        tick();
        tick();
        chk("wr_idle", 32'(bus.busy), 32'd0);

        // Read 0x00 returning 0x24
        bus.reg_addr = 6'h00;
        bus.reg_read_req = 1'b1;
        sb.push_back('{wr: 1'b0, err: 1'b0, data: 8'h24});
        phy_read("rd", 8'hC0, 8'h24);
        bus.reg_read_req = 1'b0;
        tick();
        tick();
        chk("rd_idle", 32'(bus.busy), 32'd0);
        chk("rd_data_held", 32'(bus.reg_data_read), 32'h24);

        // DIR rises during WR_CMD: bus released at once, TXCMD reissued, single ack
        a0 = acks;
        bus.reg_addr = 6'h15;
        bus.reg_data_write = 8'hA3;
        bus.reg_write_req = 1'b1;
        sb.push_back('{wr: 1'b1, err: 1'b0, data: 8'h00});
        wait_tx("ab_first_txcmd", 8'h95);
        bus.ulpi_dir = 1'b1;
        #1;
        chk("ab_oe_same_cycle", 32'(bus.ulpi_d_oe), 32'd0);
        tick();
        chk("ab_busy", 32'(bus.busy), 32'd1);
        tick();
        bus.ulpi_dir = 1'b0;
        phy_write("ab", 8'h95, 8'hA3);
        bus.reg_write_req = 1'b0;
        tick();
        tick();
        chk("ab_ack_count", 32'(acks - a0), 32'd1);

        // NXT never comes: ack+ERR 64 cycles after entering WR_CMD (entered 1 cycle after req)
        bus.reg_addr = 6'h3F;
        bus.reg_data_write = 8'h00;
        bus.reg_write_req = 1'b1;
        sb.push_back('{wr: 1'b1, err: 1'b1, data: 8'h00});
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (bus.reg_write_ack) begin
                cyc = i;
                break;
            end
        end
        chk("tmo_latency", 32'(cyc), 32'd65);
        chk("tmo_oe", 32'(bus.ulpi_d_oe), 32'd0);
        bus.reg_write_req = 1'b0;
        tick();
        tick();
        chk("tmo_oe_after", 32'(bus.ulpi_d_oe), 32'd0);
        chk("tmo_idle", 32'(bus.busy), 32'd0);

        // Write and read together: write first, read only after write req drops
        a0 = acks;
        bus.reg_addr = 6'h01;
        bus.reg_data_write = 8'h11;
        bus.reg_write_req = 1'b1;
        bus.reg_read_req = 1'b1;
        sb.push_back('{wr: 1'b1, err: 1'b0, data: 8'h00});
        sb.push_back('{wr: 1'b0, err: 1'b0, data: 8'h5A});
        phy_write("both_wr", 8'h81, 8'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("both_hold_oe", 32'(bus.ulpi_d_oe), 32'd0);
            chk("both_hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.reg_write_req = 1'b0;
        phy_read("both_rd", 8'hC1, 8'h5A);
        bus.reg_read_req = 1'b0;
        tick();
        tick();
        chk("both_ack_count", 32'(acks - a0), 32'd2);

        // Four PHY aborts of a read: three retries then ack+ERR, DATA_READ kept
        bus.reg_addr = 6'h2A;
        bus.reg_read_req = 1'b1;
        sb.push_back('{wr: 1'b0, err: 1'b1, data: 8'h5A});
        for (int r = 0; r < 4; r++) begin
            wait_tx("retry_txcmd", 8'hEA);
            bus.ulpi_dir = 1'b1;
            tick();
            tick();
            bus.ulpi_dir = 1'b0;
        end
        wait_ack("retry_fail_ack");
        chk("retry_err", 32'(bus.reg_err), 32'd1);
        bus.reg_read_req = 1'b0;
        tick();
        tick();

        // Reset in WR_DATA: immediate release, then the still-held req completes
        bus.reg_addr = 6'h07;
        bus.reg_data_write = 8'hC3;
        bus.reg_write_req = 1'b1;
        sb.push_back('{wr: 1'b1, err: 1'b0, data: 8'h00});
        wait_tx("rst_txcmd", 8'h87);
        bus.ulpi_nxt = 1'b1;
        tick();
        chk("rst_in_wr_data", 32'(bus.ulpi_d_out), 32'hC3);
        rst = 1'b1;
        bus.ulpi_nxt = 1'b0;
        #1;
        chk("rst_mid_oe", 32'(bus.ulpi_d_oe), 32'd0);
        chk("rst_mid_stp", 32'(bus.ulpi_stp), 32'd0);
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b0;
        phy_write("post_rst", 8'h87, 8'hC3);
        bus.reg_write_req = 1'b0;
        tick();
        tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
